// File: rtl/tlc_multiway_sensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_pkg
//  Purpose  : Shared types for the multi-way sensor traffic light controller.
//             Holds the phase encoding, the phase enum, the per-way lamp set
//             and a helper that turns (phase, ownership) into a lamp set.
//  Revision : 1.0  initial release
// ============================================================================
package tlc_pkg;

   localparam logic [1:0] PH_ALLRED = 2'd0;
   localparam logic [1:0] PH_GREEN  = 2'd1;
   localparam logic [1:0] PH_YELLOW = 2'd2;

   typedef enum logic [1:0] {
      ST_ALLRED = PH_ALLRED,
      ST_GREEN  = PH_GREEN,
      ST_YELLOW = PH_YELLOW
   } phase_t;

   typedef struct packed {
      logic r;
      logic y;
      logic g;
   } lamp_t;

   // Lamp set for one approach: only the owner of green/yellow leaves red.
   function automatic lamp_t lamp_for(input phase_t ph, input logic owner);
      lamp_t l;
      l = '{r: 1'b1, y: 1'b0, g: 1'b0};
      if (owner && (ph == ST_GREEN)) begin
         l = '{r: 1'b0, y: 1'b0, g: 1'b1};
      end else if (owner && (ph == ST_YELLOW)) begin
         l = '{r: 1'b0, y: 1'b1, g: 1'b0};
      end
      return l;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_multiway_sensor_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_rr_pick
//  Purpose  : Combinational round-robin picker. Searches pending requests
//             cyclically starting at cur+1 and checking cur itself last.
//  Ports    : pending  in  NUM_WAYS  latched requests per approach
//             cur      in  WAY_W     current owner
//             next_way out WAY_W     first pending way found (cur if none)
//             found    out 1         at least one way is pending
//  Revision : 1.0  initial release
// ============================================================================
module tlc_rr_pick #(
   parameter int NUM_WAYS = 4,
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0] pending,
   input  logic [WAY_W-1:0]    cur,
   output logic [WAY_W-1:0]    next_way,
   output logic                found
);

   function automatic logic [WAY_W-1:0] wrap_add(input logic [WAY_W-1:0] base,
                                                 input int k);
      return WAY_W'((int'(base) + k) % NUM_WAYS);
   endfunction

   // Scan from the farthest offset down to the nearest so that the nearest
   // pending way (in cyclic order after cur) overwrites all others.
   always_comb begin
      next_way = cur;
      found    = 1'b0;
      for (int k = NUM_WAYS; k >= 1; k--) begin
         if (pending[wrap_add(cur, k)]) begin
            next_way = wrap_add(cur, k);
            found    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tlc_multiway_sensor.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_multiway_sensor
//  Purpose  : Sensor-actuated traffic light controller for NUM_WAYS
//             approaches. One approach holds green at a time; every change
//             of right-of-way goes GREEN -> YELLOW -> ALLRED -> GREEN.
//             Detections are latched and served round-robin.
//  Ports    : clk        in  1         clock
//             reset      in  1         asynchronous active-high reset
//             tick       in  1         timebase enable for timer and FSM
//             req        in  NUM_WAYS  vehicle sensors
//             red        out NUM_WAYS  red lamps
//             yellow     out NUM_WAYS  yellow lamps
//             green      out NUM_WAYS  green lamps
//             active_way out WAY_W     owner of green/yellow (last owner in all-red)
//             phase      out 2         0 = ALLRED, 1 = GREEN, 2 = YELLOW
//  Revision : 1.0  initial release
// ============================================================================
module tlc_multiway_sensor
   import tlc_pkg::*;
#(
   parameter int NUM_WAYS  = 4,
   parameter int CNT_W     = 8,
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WAY_W     = $clog2(NUM_WAYS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic [NUM_WAYS-1:0] req,
   output logic [NUM_WAYS-1:0] red,
   output logic [NUM_WAYS-1:0] yellow,
   output logic [NUM_WAYS-1:0] green,
   output logic [WAY_W-1:0]    active_way,
   output logic [1:0]          phase
);

   // Terminal counts: a phase ends on the tick where timer equals these.
   localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
   localparam logic [WAY_W-1:0] CUR_RESET  = WAY_W'(NUM_WAYS - 1);

   phase_t              state, state_nxt;
   logic [CNT_W-1:0]    timer, timer_nxt;
   logic [WAY_W-1:0]    cur, cur_nxt;
   logic [NUM_WAYS-1:0] pending, pending_nxt;
   logic                enter_green;

   logic [NUM_WAYS-1:0] cur_mask;
   logic [NUM_WAYS-1:0] green_mask;
   logic [NUM_WAYS-1:0] clear_mask;
   logic [NUM_WAYS-1:0] others;
   logic [NUM_WAYS-1:0] red_nxt, yellow_nxt, green_nxt;

   logic [WAY_W-1:0]    pick_way;
   logic                pick_found;
   logic [WAY_W-1:0]    cur_plus1;

   tlc_rr_pick #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
   ) u_pick (
      .pending  (pending),
      .cur      (cur),
      .next_way (pick_way),
      .found    (pick_found)
   );

   assign cur_plus1 = WAY_W'((int'(cur) + 1) % NUM_WAYS);
   assign others    = pending & ~cur_mask;

   // Per-way masks and next lamp values.
   generate
      for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
         lamp_t lamp_i;
         assign cur_mask[i]   = (cur == WAY_W'(i));
         assign green_mask[i] = (state == ST_GREEN) && cur_mask[i];
         assign clear_mask[i] = enter_green && (cur_nxt == WAY_W'(i));
         assign lamp_i        = lamp_for(state_nxt, cur_nxt == WAY_W'(i));
         assign red_nxt[i]    = lamp_i.r;
         assign yellow_nxt[i] = lamp_i.y;
         assign green_nxt[i]  = lamp_i.g;
      end
   endgenerate

   // A way cannot request while it is green; the clear on green entry
   // takes priority over a set arriving on the same edge.
   assign pending_nxt = (pending | (req & ~green_mask)) & ~clear_mask;

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      cur_nxt     = cur;
      enter_green = 1'b0;
      if (tick) begin
         timer_nxt = timer + CNT_W'(1);
         case (state)
            ST_ALLRED: begin
               if (timer == ALLRED_END) begin
                  state_nxt   = ST_GREEN;
                  timer_nxt   = '0;
                  cur_nxt     = pick_found ? pick_way : cur_plus1;
                  enter_green = 1'b1;
               end
            end
            ST_GREEN: begin
               if (((timer >= GMIN_END) && (others != '0)) || (timer == GMAX_END)) begin
                  state_nxt = ST_YELLOW;
                  timer_nxt = '0;
               end
            end
            ST_YELLOW: begin
               if (timer == YELLOW_END) begin
                  state_nxt = ST_ALLRED;
                  timer_nxt = '0;
               end
            end
            default: begin
               state_nxt = ST_ALLRED;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next-state values so they change on
   // the same edge as the state itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_ALLRED;
         timer      <= '0;
         cur        <= CUR_RESET;
         pending    <= '0;
         red        <= '1;
         yellow     <= '0;
         green      <= '0;
         active_way <= CUR_RESET;
         phase      <= PH_ALLRED;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         cur        <= cur_nxt;
         pending    <= pending_nxt;
         red        <= red_nxt;
         yellow     <= yellow_nxt;
         green      <= green_nxt;
         active_way <= cur_nxt;
         phase      <= state_nxt;
      end
   end

endmodule
`default_nettype wire

// File: doc/tlc_multiway_sensor.md
# tlc_multiway_sensor

Parametrised, sensor-actuated traffic light controller for an intersection of `NUM_WAYS` approaches. It is the successor to our fixed two-road sensor controller. Phase timing runs on a prescaled `tick`, and min-green, max-green, yellow and all-red clearance are all configurable. Vehicle detections are latched per approach and served in round-robin order. Only one approach holds green at a time, and every change of right-of-way passes through yellow and all-red.

## Interface
- `NUM_WAYS`, 4: number of approaches; must be ≥ 2.
- `CNT_W`, 8: phase timer width; every duration parameter must be < 2^CNT_W.
- `GREEN_MIN`, 4: minimum green, in ticks; must be ≥ 1.
- `GREEN_MAX`, 10: maximum green, in ticks; must be ≥ `GREEN_MIN`.
- `YELLOW_T`, 2: yellow duration, in ticks; must be ≥ 1.
- `ALLRED_T`, 1: all-red clearance, in ticks; must be ≥ 1.
- `WAY_W`, `$clog2(NUM_WAYS)`: width of the way index (derived).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `tick` in 1: timebase enable; the timer and FSM advance only on cycles where `tick`=1.
- `req` in NUM_WAYS: per-approach vehicle sensor, level or pulse, sampled every clk.
- `red` out NUM_WAYS: red lamp per approach.
- `yellow` out NUM_WAYS: yellow lamp per approach.
- `green` out NUM_WAYS: green lamp per approach.
- `active_way` out WAY_W: approach currently owning green or yellow, or the last owner during all-red.
- `phase` out 2: current phase; 0 = ALLRED, 1 = GREEN, 2 = YELLOW.

## Operation
- Reset values: state ALLRED, `timer`=0, `cur`=NUM_WAYS-1, `pending`=0, `red`=all 1, `yellow`=0, `green`=0, `active_way`=NUM_WAYS-1, `phase`=0.
- Pending latch, evaluated every clk regardless of `tick`:
  - `pending[i]` sets when `req[i]`=1, unless way i is currently GREEN.
  - `pending[i]` clears on the clk edge that enters GREEN for way i; the clear wins over a simultaneous set.
- `others` = `pending` with bit `cur` masked off.
- Timer behaviour: the timer resets to 0 on every state entry and increments on each tick within a state.
- ALLRED: on the tick where `timer`=ALLRED_T-1, enter GREEN.
  - New `cur` is the first way with `pending` set, searching cyclically from `cur`+1 and checking `cur` itself last.
  - If nothing is pending, new `cur` = (`cur`+1) mod NUM_WAYS (default rotation).
- GREEN: on a tick, enter YELLOW if either condition holds; otherwise hold GREEN.
  - `timer` ≥ GREEN_MIN-1 and `others` ≠ 0.
  - `timer` = GREEN_MAX-1, regardless of requests.
- YELLOW: on the tick where `timer`=YELLOW_T-1, enter ALLRED; `cur` is unchanged.
- Lamps:
  - Way `cur` shows green in GREEN and yellow in YELLOW.
  - Every other way shows red, and all ways show red in ALLRED.
  - Exactly one lamp per way is lit at all times.
  - At most one way is non-red at any time.
- Simultaneous requests are resolved by the round-robin search above; no approach is served twice while another is pending.

## Timing
- All outputs are registered and updated on the same clk edge as the state change; there is no combinational path from `req` or `tick` to any output.
- Per-phase durations with `tick` held at 1: ALLRED lasts ALLRED_T clk, YELLOW lasts YELLOW_T clk, and GREEN lasts between GREEN_MIN and GREEN_MAX clk.
- A request arriving during GREEN of another way, with `timer` already ≥ GREEN_MIN-1, causes a YELLOW entry 2 clk after `req` rises: the first edge latches `pending`, the second transitions.
- `tick`=0 freezes the timer, state and outputs; `pending` still latches.
- `reset` asserted mid-phase forces all-red outputs, clears `pending`, and restarts from the reset state asynchronously.

## Structure
- Package `tlc_pkg` holds:
  - the phase encoding constants `PH_ALLRED`=2'd0, `PH_GREEN`=2'd1, `PH_YELLOW`=2'd2;
  - a phase typedef;
  - a lamp-set struct holding {r, y, g}.
- Sub-module `tlc_rr_pick` is combinational: it takes `pending` and `cur` and returns the next way index plus a `found` flag. It is parametrised by NUM_WAYS.
- Top level contains the FSM, timer, pending register and output registers.

## Test plan
All scenarios use the defaults (N=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1) with `tick`=1 unless stated.
- Reset, no requests:
  - After reset release: ALLRED for 1 clk, then way 0 green for 10 clk, yellow for 2, all-red for 1, then way 1 green.
  - Rotation continues through 0→1→2→3→0 with a 13-clk period per way.
- Single-cycle `req[2]` pulse during way 0 green at `timer`=1:
  - Way 0 green totals 4 clk, then yellow 2, all-red 1, then way 2 green.
  - `pending[2]` clears on way 2's green entry.
- `req[1]` and `req[3]` asserted in the same cycle during way 0 green:
  - Way 1 is served first with exactly 4 clk of green, because `pending[3]` is set.
  - Way 3 is served next; way 2 is skipped.
- `tick` held at 0 for 20 clk mid-GREEN while `req[1]` pulses:
  - Lamps, `phase` and `timer` are unchanged throughout.
  - `pending[1]`=1, and YELLOW follows on the first tick once `timer` ≥ 3.
- `reset` asserted during way 2 YELLOW:
  - Same cycle, asynchronously: `red`=4'b1111, `green`=0, `yellow`=0, `phase`=0, `pending`=0.
  - After release, the first green goes to way 0.
- Invariant checked every clk: each way has exactly one lamp lit, and at most one way is non-red.
